// File: rtl/data_sram_resp_if.sv
// Data-SRAM request/response bus between the EX/MEM requester and the SRAM responder.
interface data_sram_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq_mem;
    logic        access_err;

    modport master (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, stallreq_mem, access_err
    );

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, stallreq_mem, access_err
    );
endinterface

// File: rtl/data_sram_resp.sv
// Behavioural single-port data SRAM responder with optional wait states and
// a stall request held for the duration of each slow access.
module data_sram_resp #(
    parameter int unsigned ADDR_WD     = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    data_sram_resp_if.slave  sram_io
);
    localparam int unsigned DEPTH = 1 << ADDR_WD;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {IDLE, BUSY} state_e;

    logic [31:0]        mem_q [DEPTH];
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         wen_q, wen_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               stall_q, stall_d;

    logic               commit_c;
    logic [31:0]        cmt_addr_c;
    logic [3:0]         cmt_wen_c;
    logic [31:0]        cmt_wdata_c;
    logic [31:0]        off_c;
    logic               in_range_c;
    logic               wen_ok_c;
    logic               legal_c;
    logic [ADDR_WD-1:0] idx_c;

    // Next-state, commit selection, legality and registered-output values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        commit_c    = 1'b0;
        cmt_addr_c  = sram_io.data_sram_addr;
        cmt_wen_c   = sram_io.data_sram_wen;
        cmt_wdata_c = sram_io.data_sram_wdata;

        case (state_q)
            IDLE: begin
                if (sram_io.data_sram_en) begin
                    if (WAIT_CYCLES == 0) begin
                        commit_c = 1'b1;
                    end else begin
                        addr_d  = sram_io.data_sram_addr;
                        wen_d   = sram_io.data_sram_wen;
                        wdata_d = sram_io.data_sram_wdata;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d       = cnt_q - CNT_W'(1);
                cmt_addr_c  = addr_q;
                cmt_wen_c   = wen_q;
                cmt_wdata_c = wdata_q;
                if (cnt_q == CNT_W'(1)) begin
                    commit_c = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Range test on the offset before truncation to the word index
        off_c      = cmt_addr_c - BASE_ADDR;
        in_range_c = (off_c >> (ADDR_WD + 2)) == 32'd0;
        idx_c      = off_c[ADDR_WD+1:2];
        case (cmt_wen_c)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b1000, 4'b0011, 4'b1100, 4'b1111: wen_ok_c = 1'b1;
            default:                            wen_ok_c = 1'b0;
        endcase
        legal_c = in_range_c && wen_ok_c;

        stall_d = (state_d == BUSY);
        err_d   = commit_c && !legal_c;
        rdata_d = rdata_q;
        if (commit_c) begin
            rdata_d = legal_c ? mem_q[idx_c] : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wen_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    // Array is never cleared; reset only suppresses a pending write
    always_ff @(posedge clk) begin
        if (!rst && commit_c && legal_c) begin
            for (int b = 0; b < 4; b++) begin
                if (cmt_wen_c[b]) begin
                    mem_q[idx_c][8*b +: 8] <= cmt_wdata_c[8*b +: 8];
                end
            end
        end
    end

    assign sram_io.data_sram_rdata = rdata_q;
    assign sram_io.stallreq_mem    = stall_q;
    assign sram_io.access_err      = err_q;
endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: one zero-wait and one three-wait instance,
// with a scoreboard of expected responses pushed at issue and popped at response.
module tb_data_sram_resp;
    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        bit          chk;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst0, rst3;
    int   checks   = 0;
    int   failures = 0;

    exp_t        q0[$];
    exp_t        q3[$];
    bit [31:0]   m0[int];
    bit [31:0]   m3[int];
    bit          last0_known, last3_known;
    logic [31:0] last0, last3;

    data_sram_resp_if if0();
    data_sram_resp_if if3();

    data_sram_resp #(.ADDR_WD(10), .BASE_ADDR(BASE), .WAIT_CYCLES(0))
        u_dut0 (.clk(clk), .rst(rst0), .sram_io(if0));
    data_sram_resp #(.ADDR_WD(10), .BASE_ADDR(BASE), .WAIT_CYCLES(3))
        u_dut3 (.clk(clk), .rst(rst3), .sram_io(if3));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] a, input logic [3:0] w);
        logic [31:0] off;
        off = a - BASE;
        return (off < 32'h0000_1000) &&
               (w inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                          4'b1000, 4'b0011, 4'b1100, 4'b1111});
    endfunction

    task automatic predict(input bit d3, input logic [3:0] wen, input logic [31:0] addr,
                           input logic [31:0] wdata, output exp_t e);
        int          i;
        bit          known;
        logic [31:0] old, nv;
        e.chk = 1'b1; e.rdata = 32'd0; e.err = 1'b1;
        if (is_legal(addr, wen)) begin
            i     = int'((addr - BASE) >> 2);
            known = d3 ? m3.exists(i) : m0.exists(i);
            old   = known ? (d3 ? m3[i] : m0[i]) : 32'd0;
            e.chk = known; e.rdata = old; e.err = 1'b0;
            if (wen == 4'hF || (wen != 4'h0 && known)) begin
                nv = old;
                for (int b = 0; b < 4; b++)
                    if (wen[b]) nv[8*b +: 8] = wdata[8*b +: 8];
                if (d3) m3[i] = nv; else m0[i] = nv;
            end
        end
    endtask

    task automatic step0(input string tag, input bit en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e, o;
        if0.data_sram_en = en; if0.data_sram_wen = wen;
        if0.data_sram_addr = addr; if0.data_sram_wdata = wdata;
        if (en) begin
            predict(1'b0, wen, addr, wdata, e);
            last0_known = e.chk; last0 = e.rdata;
        end else begin
            e.chk = last0_known; e.rdata = last0; e.err = 1'b0;
        end
        q0.push_back(e);
        @(posedge clk); #1;
        o = q0.pop_front();
        if (o.chk) chk({tag, " rdata"}, if0.data_sram_rdata, o.rdata);
        chk({tag, " err"}, 32'(if0.access_err), 32'(o.err));
        chk({tag, " stall"}, 32'(if0.stallreq_mem), 32'd0);
    endtask

    // Issue one slow access; optionally drive a conflicting write to word 4 while busy
    task automatic step3(input string tag, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit garbage);
        exp_t e, o;
        int   n;
        if3.data_sram_en = 1'b1; if3.data_sram_wen = wen;
        if3.data_sram_addr = addr; if3.data_sram_wdata = wdata;
        predict(1'b1, wen, addr, wdata, e);
        last3_known = e.chk; last3 = e.rdata;
        q3.push_back(e);
        @(posedge clk); #1;
        if3.data_sram_en = 1'b0;
        n = 0;
        while (if3.stallreq_mem === 1'b1 && n < 20) begin
            n++;
            if (garbage) begin
                if3.data_sram_en    = 1'b1;
                if3.data_sram_wen   = 4'hF;
                if3.data_sram_addr  = BASE + 32'h10;
                if3.data_sram_wdata = $urandom;
            end
            @(posedge clk); #1;
        end
        if3.data_sram_en = 1'b0;
        o = q3.pop_front();
        chk({tag, " stall_cycles"}, 32'(n), 32'd3);
        if (o.chk) chk({tag, " rdata"}, if3.data_sram_rdata, o.rdata);
        chk({tag, " err"}, 32'(if3.access_err), 32'(o.err));
        @(posedge clk); #1;
        chk({tag, " err_next"}, 32'(if3.access_err), 32'd0);
        chk({tag, " stall_idle"}, 32'(if3.stallreq_mem), 32'd0);
    endtask

    initial begin
        if0.data_sram_en = 1'b0; if0.data_sram_wen = '0; if0.data_sram_addr = '0; if0.data_sram_wdata = '0;
        if3.data_sram_en = 1'b0; if3.data_sram_wen = '0; if3.data_sram_addr = '0; if3.data_sram_wdata = '0;
        rst0 = 1'b1; rst3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0; rst3 = 1'b0;
        last0_known = 1'b1; last0 = 32'd0;
        last3_known = 1'b1; last3 = 32'd0;

        chk("rst0 rdata", if0.data_sram_rdata, 32'd0);
        chk("rst0 stall", 32'(if0.stallreq_mem), 32'd0);
        chk("rst0 err",   32'(if0.access_err), 32'd0);
        chk("rst3 rdata", if3.data_sram_rdata, 32'd0);
        chk("rst3 stall", 32'(if3.stallreq_mem), 32'd0);
        chk("rst3 err",   32'(if3.access_err), 32'd0);

        // Zero-wait: full word write, read-back, then byte and halfword merges
        step0("w0 full",   1'b1, 4'b1111, 32'h8000_0010, 32'hDEAD_BEEF);
        step0("w0 rd1",    1'b1, 4'b0000, 32'h8000_0010, 32'h0);
        step0("w0 hold",   1'b0, 4'b0000, 32'h8000_0010, 32'h0);
        step0("w0 byte2",  1'b1, 4'b0100, 32'h8000_0010, 32'h00AA_0000);
        step0("w0 rd2",    1'b1, 4'b0000, 32'h8000_0010, 32'h0);
        step0("w0 half0",  1'b1, 4'b0011, 32'h8000_0010, 32'h0000_1234);
        step0("w0 rd3",    1'b1, 4'b0000, 32'h8000_0010, 32'h0);

        // Seed words 0..2 and the top word
        step0("w0 seed0",  1'b1, 4'b1111, 32'h8000_0000, 32'h0000_0011);
        step0("w0 seed1",  1'b1, 4'b1111, 32'h8000_0004, 32'h0000_0022);
        step0("w0 seed2",  1'b1, 4'b1111, 32'h8000_0008, 32'h0000_0033);
        step0("w0 seedtop",1'b1, 4'b1111, 32'h8000_0FFC, 32'h5555_AAAA);

        // Rejected accesses and boundaries
        step0("w0 below",  1'b1, 4'b0000, 32'h7FFF_FFFC, 32'h0);
        step0("w0 rdtop",  1'b1, 4'b0000, 32'h8000_0FFC, 32'h0);
        step0("w0 badwen", 1'b1, 4'b0110, 32'h8000_0000, 32'hFFFF_FFFF);
        step0("w0 hold0",  1'b0, 4'b0000, 32'h8000_0000, 32'h0);
        step0("w0 above",  1'b1, 4'b0000, 32'h8000_1000, 32'h0);

        // Back-to-back reads of words 0,1,2
        step0("w0 b2b0",   1'b1, 4'b0000, 32'h8000_0000, 32'h0);
        step0("w0 b2b1",   1'b1, 4'b0000, 32'h8000_0004, 32'h0);
        step0("w0 b2b2",   1'b1, 4'b0000, 32'h8000_0008, 32'h0);
        step0("w0 idle",   1'b0, 4'b0000, 32'h0, 32'h0);

        // Three-wait instance
        step3("w3 seed3",  4'b1111, 32'h8000_000C, 32'h1234_5678, 1'b0);
        step3("w3 seed4",  4'b1111, 32'h8000_0010, 32'h0A0B_0C0D, 1'b0);
        step3("w3 rd3",    4'b0000, 32'h8000_000C, 32'h0, 1'b1);
        step3("w3 below",  4'b0000, 32'h7FFF_FFFC, 32'h0, 1'b0);
        step3("w3 rd3b",   4'b0000, 32'h8000_000C, 32'h0, 1'b0);

        // Reset in the second busy cycle discards the pending write
        if3.data_sram_en = 1'b1; if3.data_sram_wen = 4'hF;
        if3.data_sram_addr = 32'h8000_0010; if3.data_sram_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        if3.data_sram_en = 1'b0;
        chk("w3 rst busy1", 32'(if3.stallreq_mem), 32'd1);
        @(posedge clk); #1;
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        chk("w3 rst stall", 32'(if3.stallreq_mem), 32'd0);
        chk("w3 rst rdata", if3.data_sram_rdata, 32'd0);
        chk("w3 rst err",   32'(if3.access_err), 32'd0);
        step3("w3 rd4",    4'b0000, 32'h8000_0010, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder side of the data-SRAM interface: behavioural single-port data memory for simulation and FPGA bring-up.
- Answers requests issued by the EX stage (en/wen/addr/wdata).
- Returns read words on data_sram_rdata, which the MEM stage byte-selects and extends in the following cycle.
- Models a configurable wait-state count and raises a stall request to the pipeline stall controller while a slow access is in flight.

Parameters:
- ADDR_WD, 10: word-address width; memory depth = 2^ADDR_WD 32-bit words.
- BASE_ADDR, 32'h8000_0000: byte address of word 0; must be aligned to depth*4.
- WAIT_CYCLES, 0: extra cycles per access; 0 = single-cycle SRAM; legal range 0..15.

Ports:
- clk, input, 1: clock, all state on posedge.
- rst, input, 1: synchronous active-high reset.
- data_sram_en, input, 1: access request this cycle.
- data_sram_wen, input, 4: byte write enables; 4'b0000 = read.
- data_sram_addr, input, 32: byte address; bits [1:0] ignored for indexing.
- data_sram_wdata, input, 32: store data, already lane-replicated by the requester.
- data_sram_rdata, output, 32: registered read word.
- stallreq_mem, output, 1: high while an access is in its wait states.
- access_err, output, 1: one-cycle pulse reporting a rejected access.

Behaviour:
- Reset values: data_sram_rdata=0, stallreq_mem=0, access_err=0, state=IDLE, wait counter=0. Memory array is not cleared by reset.
- States:
  - IDLE: accepts requests.
  - BUSY: counting wait states; exists only when WAIT_CYCLES>0.
- Legality check, evaluated at acceptance:
  - In range: (addr - BASE_ADDR) < depth*4.
  - Legal wen: 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - Illegal request: no memory change, rdata <= 0 at the commit edge, access_err pulses high for exactly the cycle after commit.
- Commit action at the commit edge:
  - Read (wen=0): rdata <= mem[idx].
  - Write: only the enabled bytes of mem[idx] are updated from wdata; rdata <= old mem[idx] (read-first).
- WAIT_CYCLES=0:
  - IDLE with en=1: commit on the same edge; rdata is valid in the next cycle; stallreq_mem stays 0.
  - Back-to-back requests are accepted every cycle.
- WAIT_CYCLES=N>0, acceptance:
  - IDLE with en=1: latch addr/wen/wdata, counter <= N, go to BUSY. No commit on this edge.
- WAIT_CYCLES=N>0, in BUSY:
  - stallreq_mem=1 (Moore output, state==BUSY); all inputs are ignored.
  - Counter decrements each edge.
  - Edge where counter==1: commit using the latched request, return to IDLE.
  - Result: stallreq_mem is high exactly N cycles; rdata is valid in the first IDLE cycle after BUSY.
- data_sram_rdata holds its value until the next commit. en=0 leaves it unchanged.
- en=1 arriving in the same cycle as BUSY->IDLE: that request is ignored. The stall controller guarantees a re-issue.
- rst asserted mid-BUSY: the pending access is discarded with no memory write; all outputs return to reset values on that edge.
- Address index = (addr - BASE_ADDR) >> 2, truncated to ADDR_WD bits after the range check.

Test Plan:
- WAIT=0; write en=1, wen=1111, addr=8000_0010, wdata=DEADBEEF; then read same addr -> rdata=DEADBEEF in the cycle after the read request; stallreq_mem never high.
- WAIT=0; after the word holds DEADBEEF, write wen=0100, wdata=00AA0000; read -> DEAABEEF. Then wen=0011, wdata=00001234; read -> DEAA1234.
- WAIT=0; read at 7FFF_FFFC and write wen=0110 at 8000_0000 -> access_err pulses one cycle each, rdata=0, word 0 unchanged.
- WAIT=3; read of a word holding 12345678 -> stallreq_mem high exactly 3 cycles, rdata=12345678 in the following cycle; changing addr during BUSY has no effect.
- WAIT=3; write wen=1111, wdata=CAFEF00D with rst pulsed in the 2nd BUSY cycle -> stallreq_mem=0 next cycle, rdata=0; a later read of the word returns its prior contents, not CAFEF00D.
- WAIT=0; three back-to-back reads of words 0,1,2 holding 11,22,33 -> rdata=11,22,33 on consecutive cycles.
